dmem_bus_arbiter: RTL and testbench

Two-port arbiter that shares the single data-memory/peripheral bus (DataMem plus the Peripheral address space) between the CPU load/store port (port 0) and a secondary master such as a UART receive DMA (port 1). It grants at most one access per cycle, registers the winning command onto the bus, and routes read data back to the issuing port. Port 0 has fixed priority, and a starvation guard protects port 1.

---
 rtl/dmem_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bus_arbiter.sv
// rtl/dmem_bus_arbiter.sv - two-port data-memory bus arbiter, port 0 priority with starvation guard.
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin contention instead of the guard.
module dmem_bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_wr,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_wr,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    logic          mem_rd_q, mem_rd_d;
    logic          mem_wr_q, mem_wr_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          rd_owner_q, rd_owner_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;
    logic          p1_wins_tie;
    logic          gnt_any;
    logic          win_wr;

`ifdef ARB_ROUND_ROBIN_EN
    // last_q = 1 means port 1 was granted most recently, so port 0 takes the next tie.
    logic last_q, last_d;

    assign p1_wins_tie = ~last_q;

    always_comb begin
        last_d = last_q;
        if (gnt_any) last_d = p1_gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) last_q <= 1'b1;
        else        last_q <= last_d;
    end
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    logic [3:0] wait_q, wait_d;

    assign p1_wins_tie = (wait_q == MAX_WAIT_C);

    always_comb begin
        wait_d = wait_q;
        if (!p1_req || p1_gnt)       wait_d = 4'd0;
        else if (wait_q != MAX_WAIT_C) wait_d = wait_q + 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) wait_q <= 4'd0;
        else        wait_q <= wait_d;
    end
`endif

    // Grant depends only on requests and arbitration state, never on bus read data.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (p0_req && p1_req) begin
            if (p1_wins_tie) p1_gnt = 1'b1;
            else             p0_gnt = 1'b1;
        end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
        end
    end

    assign gnt_any = p0_gnt | p1_gnt;
    assign win_wr  = p1_gnt ? p1_wr : p0_wr;

    always_comb begin
        mem_rd_d    = gnt_any & ~win_wr;
        mem_wr_d    = gnt_any & win_wr;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_owner_d  = rd_owner_q;
        if (gnt_any) begin
            mem_addr_d  = p1_gnt ? p1_addr  : p0_addr;
            mem_wdata_d = p1_gnt ? p1_wdata : p0_wdata;
            if (!win_wr) rd_owner_d = p1_gnt;
        end
    end

    // Read data returns one edge after the bus read, steered to the port that issued it.
    always_comb begin
        p0_rvalid_d = mem_rd_q & ~rd_owner_q;
        p1_rvalid_d = mem_rd_q & rd_owner_q;
        p0_rdata_d  = p0_rvalid_d ? mem_rdata : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rdata : p1_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_owner_q  <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_owner_q  <= rd_owner_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = mem_rd_q | mem_wr_q;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// tb/tb_dmem_bus_arbiter.sv - scoreboard bench for dmem_bus_arbiter.
module tb_dmem_bus_arbiter;

    typedef struct packed {
        logic        port;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    logic        clk;
    logic        reset;
    logic        p0_req, p0_wr, p1_req, p1_wr;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_rd, mem_wr, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];

    cmd_t        cmd_q0[$];
    cmd_t        cmd_q1[$];
    cmd_t        bus_exp[$];
    int          gnt_exp[$];
    logic [31:0] rd_exp0[$];
    logic [31:0] rd_exp1[$];

    int   checks = 0;
    int   errors = 0;
    int   timeouts = 0;
    logic end_req = 1'b0;
    logic prev_gnt = 1'b0;
    logic [1:0] exp_rv = 2'b00;

    dmem_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = mem_rd ? mem[mem_addr[9:2]] : 32'h0;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h04] = 32'hDEADBEEF;
        for (int i = 0; i < 8; i++) mem[8'h10 + i] = 32'h1000 + i;
        mem[8'h20] = 32'h000000A0;
        mem[8'h21] = 32'h000000A1;
        forever begin
            @(posedge clk);
            if (mem_wr) mem[mem_addr[9:2]] = mem_wdata;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required end of test");
        $fatal(1);
    end

    // Monitor: every comparison in the bench is made here.
    always @(negedge clk) begin
        cmd_t        b;
        int          g;
        logic [31:0] r;
        if (end_req) begin
            checks++;
            if (gnt_exp.size() + bus_exp.size() + rd_exp0.size() + rd_exp1.size() != 0) begin
                errors++;
                $display("FAIL leftover: %0d pending expectations, required 0",
                         gnt_exp.size() + bus_exp.size() + rd_exp0.size() + rd_exp1.size());
            end
            checks++;
            if (timeouts != 0) begin
                errors++;
                $display("FAIL driver_timeout: %0d runs timed out, required 0", timeouts);
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end else if (!reset) begin
            checks++;
            if ({p0_rvalid, p1_rvalid, mem_rd, mem_wr, busy} !== 5'b0 || p0_rdata !== 32'h0 ||
                p1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
                errors++;
                $display("FAIL reset_state: rv=%b%b rd=%b wr=%b busy=%b addr=%h wdata=%h r0=%h r1=%h, required all 0",
                         p0_rvalid, p1_rvalid, mem_rd, mem_wr, busy, mem_addr, mem_wdata, p0_rdata, p1_rdata);
            end
            prev_gnt = 1'b0;
            exp_rv   = 2'b00;
        end else begin
            checks++;
            if (busy !== prev_gnt) begin
                errors++;
                $display("FAIL busy_latency: busy=%b, required %b", busy, prev_gnt);
            end
            checks++;
            if ({p1_rvalid, p0_rvalid} !== exp_rv) begin
                errors++;
                $display("FAIL rvalid: {p1,p0}=%b%b, required %b", p1_rvalid, p0_rvalid, exp_rv);
            end
            exp_rv = 2'b00;
            if (p0_rvalid) begin
                checks++;
                if (rd_exp0.size() == 0) begin
                    errors++;
                    $display("FAIL p0_rdata: unexpected response %h, required none", p0_rdata);
                end else begin
                    r = rd_exp0.pop_front();
                    if (p0_rdata !== r) begin
                        errors++;
                        $display("FAIL p0_rdata: got %h, required %h", p0_rdata, r);
                    end
                end
            end
            if (p1_rvalid) begin
                checks++;
                if (rd_exp1.size() == 0) begin
                    errors++;
                    $display("FAIL p1_rdata: unexpected response %h, required none", p1_rdata);
                end else begin
                    r = rd_exp1.pop_front();
                    if (p1_rdata !== r) begin
                        errors++;
                        $display("FAIL p1_rdata: got %h, required %h", p1_rdata, r);
                    end
                end
            end
            if (busy) begin
                checks++;
                if (bus_exp.size() == 0) begin
                    errors++;
                    $display("FAIL bus_cmd: unexpected rd=%b wr=%b addr=%h, required idle", mem_rd, mem_wr, mem_addr);
                end else begin
                    b = bus_exp.pop_front();
                    if (mem_wr !== b.wr || mem_rd !== !b.wr || mem_addr !== b.addr ||
                        (b.wr && mem_wdata !== b.wdata)) begin
                        errors++;
                        $display("FAIL bus_cmd: rd=%b wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                                 mem_rd, mem_wr, mem_addr, mem_wdata, b.wr, b.addr, b.wdata);
                    end
                    if (!b.wr) exp_rv = b.port ? 2'b10 : 2'b01;
                end
            end
            if (p0_gnt || p1_gnt) begin
                checks++;
                if (gnt_exp.size() == 0) begin
                    errors++;
                    $display("FAIL grant: unexpected {p1,p0}=%b%b, required none", p1_gnt, p0_gnt);
                end else begin
                    g = gnt_exp.pop_front();
                    if ({p1_gnt, p0_gnt} !== ((g == 1) ? 2'b10 : 2'b01)) begin
                        errors++;
                        $display("FAIL grant: {p1,p0}=%b%b, required port %0d", p1_gnt, p0_gnt, g);
                    end
                end
            end
            prev_gnt = p0_gnt | p1_gnt;
        end
    end

    task automatic add_cmd(input int port, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rexp);
        cmd_t c;
        c.port  = (port == 1);
        c.wr    = wr;
        c.addr  = addr;
        c.wdata = wdata;
        if (port == 1) cmd_q1.push_back(c);
        else           cmd_q0.push_back(c);
        bus_exp.push_back(c);
        gnt_exp.push_back(port);
        if (!wr) begin
            if (port == 1) rd_exp1.push_back(rexp);
            else           rd_exp0.push_back(rexp);
        end
    endtask

    // Presents queued commands, holding each until its grant is sampled.
    task automatic run_cmds(input int max_cycles);
        int cyc = 0;
        while ((cmd_q0.size() != 0 || cmd_q1.size() != 0) && cyc < max_cycles) begin
            @(posedge clk); #1;
            p0_req = (cmd_q0.size() != 0);
            if (p0_req) begin
                p0_wr = cmd_q0[0].wr; p0_addr = cmd_q0[0].addr; p0_wdata = cmd_q0[0].wdata;
            end
            p1_req = (cmd_q1.size() != 0);
            if (p1_req) begin
                p1_wr = cmd_q1[0].wr; p1_addr = cmd_q1[0].addr; p1_wdata = cmd_q1[0].wdata;
            end
            @(negedge clk);
            if (p0_gnt && cmd_q0.size() != 0) void'(cmd_q0.pop_front());
            if (p1_gnt && cmd_q1.size() != 0) void'(cmd_q1.pop_front());
            cyc++;
        end
        if (cmd_q0.size() != 0 || cmd_q1.size() != 0) timeouts++;
        cmd_q0.delete();
        cmd_q1.delete();
        @(posedge clk); #1;
        p0_req = 1'b0;
        p1_req = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int pat[10];
        int c0;
        int c1;
`ifdef ARB_ROUND_ROBIN_EN
        pat = '{0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
`else
        pat = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        reset = 1'b0;
        p0_req = 1'b0; p0_wr = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0;
        p1_req = 1'b0; p1_wr = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);

        add_cmd(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        run_cmds(20);

        add_cmd(1, 1'b1, 32'h20, 32'h55, 32'h0);
        add_cmd(1, 1'b0, 32'h20, 32'h0, 32'h55);
        run_cmds(20);

        c0 = 0;
        c1 = 0;
        for (int k = 0; k < 10; k++) begin
            if (pat[k] == 0) begin
                add_cmd(0, 1'b0, 32'h40 + 32'(4 * c0), 32'h0, 32'h1000 + 32'(c0));
                c0++;
            end else begin
                add_cmd(1, 1'b0, 32'h80 + 32'(4 * c1), 32'h0, 32'hA0 + 32'(c1));
                c1++;
            end
        end
        run_cmds(40);

        // Reset lands one cycle after a p0 read grant; that read must never return.
        @(posedge clk); #1;
        p0_req = 1'b1; p0_wr = 1'b0; p0_addr = 32'h10;
        gnt_exp.push_back(0);
        @(posedge clk); #1;
        p0_req = 1'b0;
        reset  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);

        add_cmd(1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
        run_cmds(20);

        @(posedge clk); #1;
        end_req = 1'b1;
    end

endmodule
